// File: rtl/mouse_position_tracker_pkg.sv
// mouse_pkg: shared widths, screen constants, edge flag indices and clamp helper
package mouse_pkg;
   localparam int POS_W   = 12;
   localparam int DELTA_W = 9;
   localparam int ACC_W   = 14;
   localparam int SCR_MAX_X = 1019;
   localparam int SCR_MAX_Y = 763;
   localparam int CTR_X     = 511;
   localparam int CTR_Y     = 383;
   localparam int EDGE_MIN_X = 0;
   localparam int EDGE_MAX_X = 1;
   localparam int EDGE_MIN_Y = 2;
   localparam int EDGE_MAX_Y = 3;
   typedef logic [POS_W-1:0] pos_t;
   typedef logic signed [DELTA_W-1:0] delta_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   function automatic pos_t clamp(acc_t p, pos_t lo, pos_t hi);
      return (p < $signed({{(ACC_W-POS_W){1'b0}}, lo}) || lo > hi) ? lo :
             (p > $signed({{(ACC_W-POS_W){1'b0}}, hi})) ? hi : pos_t'(p[POS_W-1:0]);
   endfunction
endpackage

// File: rtl/mouse_position_tracker_if.sv
// mouse_position_tracker_if: constraint command strobes plus decoded movement packet
interface mouse_position_tracker_if;
   import mouse_pkg::*;
   pos_t   value;
   logic   setmax_x;
   logic   setmax_y;
   logic   setmin_x;
   logic   setmin_y;
   logic   set_x;
   logic   set_y;
   logic   move_valid;
   delta_t dx;
   delta_t dy;
   logic   x_ovf;
   logic   y_ovf;
   modport master(output value, setmax_x, setmax_y, setmin_x, setmin_y, set_x, set_y,
                  move_valid, dx, dy, x_ovf, y_ovf);
   modport slave(input value, setmax_x, setmax_y, setmin_x, setmin_y, set_x, set_y,
                 move_valid, dx, dy, x_ovf, y_ovf);
endinterface

// File: rtl/mouse_position_tracker_axis_tracker.sv
// axis_tracker: one axis's bounds and clamped position with set/move/re-clamp priority
module axis_tracker
   import mouse_pkg::*;
#(
   parameter int RST_MIN = 0,
   parameter int RST_MAX = SCR_MAX_X,
   parameter int RST_POS = CTR_X,
   parameter bit INVERT  = 1'b0
) (
   input  logic   clk,
   input  logic   rst_n,
   input  pos_t   value,
   input  logic   set_min,
   input  logic   set_max,
   input  logic   set_pos,
   input  logic   move,
   input  delta_t delta,
   output pos_t   pos,
   output logic   at_min,
   output logic   at_max,
   output logic   loaded
);
   pos_t min_q, max_q, nmin, nmax, npos;
   acc_t cur, d, src;
   // next bounds take effect first, then set > move > re-clamp selects the source
   always_comb begin
      nmin   = set_min ? value : min_q;
      nmax   = set_max ? value : max_q;
      cur    = $signed({{(ACC_W-POS_W){1'b0}}, pos});
      d      = acc_t'(delta);
      src    = set_pos ? $signed({{(ACC_W-POS_W){1'b0}}, value}) :
               move ? (INVERT ? cur - d : cur + d) : cur;
      loaded = set_pos | move | set_min | set_max;
      npos   = loaded ? clamp(src, nmin, nmax) : pos;
   end
   // bound, position and edge-flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q  <= pos_t'(RST_MIN);
         max_q  <= pos_t'(RST_MAX);
         pos    <= pos_t'(RST_POS);
         at_min <= (RST_POS == RST_MIN);
         at_max <= (RST_POS == RST_MAX);
      end else begin
         min_q  <= nmin;
         max_q  <= nmax;
         pos    <= npos;
         at_min <= (npos == nmin);
         at_max <= (npos == nmax);
      end
   end
endmodule

// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker: integrates PS/2 deltas into a bounded cursor position
module mouse_position_tracker
   import mouse_pkg::*;
#(
   parameter int RST_MAX_X = SCR_MAX_X,
   parameter int RST_MAX_Y = SCR_MAX_Y,
   parameter int RST_MIN_X = 0,
   parameter int RST_MIN_Y = 0,
   parameter int RST_POS_X = CTR_X,
   parameter int RST_POS_Y = CTR_Y
) (
   input  logic                     clk,
   input  logic                     rst_n,
   mouse_position_tracker_if.slave  cmd,
   output pos_t                     xpos,
   output pos_t                     ypos,
   output logic                     pos_update,
   output logic [3:0]               at_edge
);
   logic ld_x, ld_y, min_x, max_x, min_y, max_y;
   axis_tracker #(.RST_MIN(RST_MIN_X), .RST_MAX(RST_MAX_X), .RST_POS(RST_POS_X), .INVERT(1'b0)) u_x (
      .clk(clk), .rst_n(rst_n), .value(cmd.value), .set_min(cmd.setmin_x), .set_max(cmd.setmax_x),
      .set_pos(cmd.set_x), .move(cmd.move_valid & ~cmd.x_ovf), .delta(cmd.dx),
      .pos(xpos), .at_min(min_x), .at_max(max_x), .loaded(ld_x));
   // PS/2 reports up as positive while the screen grows downward, so Y subtracts
   axis_tracker #(.RST_MIN(RST_MIN_Y), .RST_MAX(RST_MAX_Y), .RST_POS(RST_POS_Y), .INVERT(1'b1)) u_y (
      .clk(clk), .rst_n(rst_n), .value(cmd.value), .set_min(cmd.setmin_y), .set_max(cmd.setmax_y),
      .set_pos(cmd.set_y), .move(cmd.move_valid & ~cmd.y_ovf), .delta(cmd.dy),
      .pos(ypos), .at_min(min_y), .at_max(max_y), .loaded(ld_y));
   assign at_edge[EDGE_MIN_X] = min_x;
   assign at_edge[EDGE_MAX_X] = max_x;
   assign at_edge[EDGE_MIN_Y] = min_y;
   assign at_edge[EDGE_MAX_Y] = max_y;
   // pulse whenever either position register was written this edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pos_update <= 1'b0;
      else pos_update <= ld_x | ld_y;
   end
endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb_mouse_position_tracker: random plus directed stimulus against a behavioural model
module tb_mouse_position_tracker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mouse_position_tracker_if cmd();
   logic [11:0] xpos, ypos;
   logic        pos_update;
   logic [3:0]  at_edge;

   mouse_position_tracker dut (
      .clk(clk), .rst_n(rst_n), .cmd(cmd),
      .xpos(xpos), .ypos(ypos), .pos_update(pos_update), .at_edge(at_edge));

   localparam logic [5:0] SMX = 6'd1, SMY = 6'd2, SNX = 6'd4, SNY = 6'd8, SX = 6'd16, SY = 6'd32;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   int m_minx, m_maxx, m_miny, m_maxy, m_px, m_py, m_upd, m_edge;

   function automatic int clampm(int p, int lo, int hi);
      if (p < lo || lo > hi) return lo;
      if (p > hi) return hi;
      return p;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: bounds first, then per-axis set > move > re-clamp
   always @(posedge clk or negedge rst_n) begin : mdl
      int nminx, nmaxx, nminy, nmaxy, nx, ny, v;
      bit lx, ly;
      if (!rst_n) begin
         m_minx <= 0; m_maxx <= 1019; m_miny <= 0; m_maxy <= 763;
         m_px <= 511; m_py <= 383; m_upd <= 0;
         m_edge <= {28'd0, 383 == 763, 383 == 0, 511 == 1019, 511 == 0};
      end else begin
         v = int'(cmd.value);
         nminx = cmd.setmin_x ? v : m_minx;
         nmaxx = cmd.setmax_x ? v : m_maxx;
         nminy = cmd.setmin_y ? v : m_miny;
         nmaxy = cmd.setmax_y ? v : m_maxy;
         nx = m_px; ny = m_py; lx = 0; ly = 0;
         if (cmd.set_x) begin nx = clampm(v, nminx, nmaxx); lx = 1; end
         else if (cmd.move_valid && !cmd.x_ovf) begin nx = clampm(m_px + int'(cmd.dx), nminx, nmaxx); lx = 1; end
         else if (cmd.setmin_x || cmd.setmax_x) begin nx = clampm(m_px, nminx, nmaxx); lx = 1; end
         if (cmd.set_y) begin ny = clampm(v, nminy, nmaxy); ly = 1; end
         else if (cmd.move_valid && !cmd.y_ovf) begin ny = clampm(m_py - int'(cmd.dy), nminy, nmaxy); ly = 1; end
         else if (cmd.setmin_y || cmd.setmax_y) begin ny = clampm(m_py, nminy, nmaxy); ly = 1; end
         m_minx <= nminx; m_maxx <= nmaxx; m_miny <= nminy; m_maxy <= nmaxy;
         m_px <= nx; m_py <= ny; m_upd <= int'(lx | ly);
         m_edge <= {28'd0, ny == nmaxy, ny == nminy, nx == nmaxx, nx == nminx};
      end
   end

   // cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("model_xpos", int'(xpos), m_px);
         chk("model_ypos", int'(ypos), m_py);
         chk("model_pos_update", int'(pos_update), m_upd);
         chk("model_at_edge", int'(at_edge), m_edge);
      end
   end

   task automatic idle();
      cmd.value = '0;
      {cmd.set_y, cmd.set_x, cmd.setmin_y, cmd.setmin_x, cmd.setmax_y, cmd.setmax_x} = '0;
      cmd.move_valid = 0; cmd.dx = '0; cmd.dy = '0; cmd.x_ovf = 0; cmd.y_ovf = 0;
   endtask

   task automatic apply(input logic [5:0] st, input logic [11:0] v, input logic mv,
                        input logic [8:0] ddx, input logic [8:0] ddy, input logic xo, input logic yo);
      cmd.value = v;
      {cmd.set_y, cmd.set_x, cmd.setmin_y, cmd.setmin_x, cmd.setmax_y, cmd.setmax_x} = st;
      cmd.move_valid = mv; cmd.dx = ddx; cmd.dy = ddy; cmd.x_ovf = xo; cmd.y_ovf = yo;
      @(negedge clk);
      idle();
   endtask

   task automatic rnd_cycle();
      cmd.value = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 1100));
      cmd.setmax_x = ($urandom_range(0, 15) == 0);
      cmd.setmax_y = ($urandom_range(0, 15) == 0);
      cmd.setmin_x = ($urandom_range(0, 15) == 0);
      cmd.setmin_y = ($urandom_range(0, 15) == 0);
      cmd.set_x = ($urandom_range(0, 9) == 0);
      cmd.set_y = ($urandom_range(0, 9) == 0);
      cmd.move_valid = 1'($urandom_range(0, 1));
      cmd.dx = 9'($urandom);
      cmd.dy = 9'($urandom);
      cmd.x_ovf = ($urandom_range(0, 7) == 0);
      cmd.y_ovf = ($urandom_range(0, 7) == 0);
      @(negedge clk);
   endtask

   initial begin
      idle();
      repeat (3) @(negedge clk);
      rst_n = 1;
      chk_en = 1;
      @(negedge clk);
      chk("reset_xpos", int'(xpos), 511);
      chk("reset_ypos", int'(ypos), 383);
      chk("reset_pos_update", int'(pos_update), 0);
      chk("reset_at_edge", int'(at_edge), 0);
      apply(SMX, 645, 0, 0, 0, 0, 0);
      chk("reclamp_pos_update", int'(pos_update), 1);
      apply(SMY, 651, 0, 0, 0, 0, 0);
      apply(SNX, 361, 0, 0, 0, 0, 0);
      apply(SNY, 367, 0, 0, 0, 0, 0);
      chk("reclamp_pos_update_last", int'(pos_update), 1);
      apply(SX, 511, 0, 0, 0, 0, 0);
      apply(SY, 460, 0, 0, 0, 0, 0);
      chk("set_xpos", int'(xpos), 511);
      chk("set_ypos", int'(ypos), 460);
      apply(0, 0, 1, 9'd200, 9'd150, 0, 0);
      chk("move_clamp_xpos", int'(xpos), 645);
      chk("move_clamp_ypos", int'(ypos), 367);
      chk("move_clamp_at_edge", int'(at_edge), 4'b0110);
      apply(0, 0, 1, 9'h100, 9'd0, 0, 0);
      chk("move_neg256_xpos", int'(xpos), 389);
      apply(SNX, 0, 0, 0, 0, 0, 0);
      apply(SMX, 1019, 0, 0, 0, 0, 0);
      apply(SX, 5, 0, 0, 0, 0, 0);
      apply(0, 0, 1, 9'h1EC, 9'd0, 0, 0);
      chk("underflow_xpos", int'(xpos), 0);
      chk("underflow_at_edge", int'(at_edge), 4'b0101);
      apply(SX, 100, 1, 9'd50, 9'h1F6, 0, 0);
      chk("set_and_move_xpos", int'(xpos), 100);
      chk("set_and_move_ypos", int'(ypos), 377);
      apply(0, 0, 1, 9'd30, 9'd30, 1, 1);
      chk("ovf_xpos", int'(xpos), 100);
      chk("ovf_ypos", int'(ypos), 377);
      chk("ovf_pos_update", int'(pos_update), 0);
      repeat (3000) rnd_cycle();
      repeat (4) apply(0, 0, 1, 9'd40, 9'h1E0, 0, 0);
      cmd.move_valid = 1; cmd.dx = 9'd60; cmd.dy = 9'd60;
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("async_rst_xpos", int'(xpos), 511);
      chk("async_rst_ypos", int'(ypos), 383);
      chk("async_rst_pos_update", int'(pos_update), 0);
      chk("async_rst_at_edge", int'(at_edge), 0);
      @(negedge clk);
      idle();
      @(negedge clk);
      rst_n = 1;
      repeat (1000) rnd_cycle();
      idle();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mouse_position_tracker.md
Name: mouse_position_tracker

Overview:
- Responder for the mouse-constraint command interface: accepts the `value` bus plus the six one-cycle strobes `setmax_x`, `setmax_y`, `setmin_x`, `setmin_y`, `set_x`, `set_y`.
- Holds the active X/Y bounds and the cursor position.
- Integrates decoded PS/2 movement packets (9-bit two's-complement deltas) into the position, clamped to the bounds.
- Sits between the PS/2 packet decoder / constraint sequencer and the drawing/game logic, which consume `xpos`/`ypos`.

Parameters:
- RST_MAX_X, 1019, max X bound after reset
- RST_MAX_Y, 763, max Y bound after reset
- RST_MIN_X, 0, min X bound after reset
- RST_MIN_Y, 0, min Y bound after reset
- RST_POS_X, 511, X position after reset
- RST_POS_Y, 383, Y position after reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  12  operand for every set strobe (unsigned)
- setmax_x  in  1  load max X bound from value
- setmax_y  in  1  load max Y bound from value
- setmin_x  in  1  load min X bound from value
- setmin_y  in  1  load min Y bound from value
- set_x  in  1  load X position from value
- set_y  in  1  load Y position from value
- move_valid  in  1  one-cycle strobe, movement packet present
- dx  in  9  signed X delta, positive = right
- dy  in  9  signed Y delta, positive = up (PS/2 convention)
- x_ovf  in  1  PS/2 X overflow bit for this packet
- y_ovf  in  1  PS/2 Y overflow bit for this packet
- xpos  out  12  cursor X, unsigned
- ypos  out  12  cursor Y, unsigned, screen-down positive
- pos_update  out  1  one-cycle pulse, position registers written
- at_edge  out  4  {max_y,min_y,max_x,min_x} hit flags, registered

Behaviour:
- Reset state:
  - Bounds = RST_* values.
  - `xpos` = RST_POS_X, `ypos` = RST_POS_Y.
  - `pos_update` = 0.
  - `at_edge` reflects the reset position: 0 with the defaults.
- Bound strobes:
  - On the rising edge with a strobe high, the corresponding bound register takes `value`.
  - Several strobes in one cycle all load the same `value`.
  - Loading a bound with no position strobe or move in the same cycle re-clamps the held position on that same edge, using the new bounds.
- Clamp function:
  - `clamp(p) = (p < min) ? min : (p > max) ? max : p`.
  - Computed on 14-bit signed intermediates, so no wrap.
  - If min > max, the result is min.
- Position strobes:
  - `set_x` loads `clamp(value)` into `xpos`, using bounds after this cycle's bound strobes. Same rule for `set_y`.
- Movement:
  - On `move_valid`, `nx = xpos + sext(dx)` and `ny = ypos - sext(dy)`.
  - Both are computed in 14-bit signed, then clamped and written on the same edge. Latency from `move_valid` to `xpos`/`ypos` is 1 cycle.
  - `x_ovf` = 1 means dx is ignored (X unchanged); `y_ovf` = 1 means dy is ignored.
- Priority per axis: `set_x`/`set_y` > movement > re-clamp.
  - `set_x` together with `move_valid`: X takes `value` and dx is dropped; Y still moves.
- `pos_update`:
  - High for 1 cycle after any edge where `xpos` or `ypos` was loaded by a set strobe, a move, or a re-clamp.
  - Fires even if the value did not change.
  - A move with both overflow bits set does not raise it.
- `at_edge[i]`: registered compare of the new position with the new bounds (equality), updated every cycle.
- Reset mid-operation: asynchronous assertion forces the reset state immediately; no pending packet survives.
- No backpressure: every strobe is accepted every cycle.

Decomposition:
- Shared package (mouse_pkg):
  - Screen constants: 1019, 763, centre 511/383.
  - POS_W = 12, DELTA_W = 9, ACC_W = 14.
  - at_edge bit indices.
- One natural sub-module, `axis_tracker`, instantiated twice with Y invert selectable by parameter. It holds one axis's min, max and pos, with the set/move/clamp logic.
- The top level wires the strobes and builds `pos_update` / `at_edge`.

Test Plan:
- Reset: release `rst_n` -> `xpos` = 511, `ypos` = 383, `pos_update` = 0, `at_edge` = 0.
- Bound sequence: `setmax_x`/645, `setmax_y`/651, `setmin_x`/361, `setmin_y`/367 on 4 consecutive cycles, then `set_x`/511, `set_y`/460 -> `xpos` = 511, `ypos` = 460; `pos_update` pulses each cycle from the first re-clamp onward.
- Move and clamp:
  - Bounds from the previous scenario, `move_valid` dx = +200, dy = +150 -> `xpos` = 645, `ypos` = 367 next cycle; `at_edge` = 4'b0110.
  - Then dx = -256 (9'h100) -> `xpos` = 389.
- Negative underflow: bounds 0..1019, `xpos` = 5, dx = -20 -> `xpos` = 0, with no wrap to 4081.
- Simultaneous and overflow:
  - `set_x`/100 with `move_valid` dx = 50, dy = -10 -> `xpos` = 100, `ypos` = old + 10.
  - `x_ovf` = 1, `y_ovf` = 1 with `move_valid` -> position unchanged, no `pos_update`.
- Async reset mid-stream: assert `rst_n` = 0 between clock edges during a move burst -> outputs return to reset values before the next edge.
